// File: rtl/snake_head_stepper.sv
// snake_head_stepper: latches non-reversing direction from KEY presses and steps the snake head with a req/ack handoff
module snake_head_stepper #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int STEP_CYCLES = 2500000,
    parameter int XW          = 6,
    parameter int YW          = 5
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    input  logic [3:0]    KEY,
    input  logic          enable,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    dir,
    output logic          mv_req,
    input  logic          mv_ack
);
    localparam int CW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state, state_n;
    logic [3:0]    key_s1, key_s2, key_prev, rise;
    logic [1:0]    cand, pend_dir, pend_dir_n, dir_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [XW-1:0] x_inc, x_dec, step_x, x_n;
    logic [YW-1:0] y_inc, y_dec, step_y, y_n;
    logic          mv_req_n;

    // key edge pick, wrap arithmetic and FSM next-state
    always_comb begin
        rise       = key_s2 & ~key_prev;
        cand       = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
        pend_dir_n = (|rise && cand != ~dir) ? cand : pend_dir;
        x_inc      = head_x == XW'(GRID_W - 1) ? '0 : head_x + 1'b1;
        x_dec      = head_x == '0 ? XW'(GRID_W - 1) : head_x - 1'b1;
        y_inc      = head_y == YW'(GRID_H - 1) ? '0 : head_y + 1'b1;
        y_dec      = head_y == '0 ? YW'(GRID_H - 1) : head_y - 1'b1;
        step_x     = pend_dir == 2'b00 ? x_inc : pend_dir == 2'b11 ? x_dec : head_x;
        step_y     = pend_dir == 2'b01 ? y_dec : pend_dir == 2'b10 ? y_inc : head_y;
        state_n    = state;
        cnt_n      = cnt;
        dir_n      = dir;
        x_n        = head_x;
        y_n        = head_y;
        mv_req_n   = mv_req;
        if (state == IDLE && enable) begin
            if (cnt == CW'(STEP_CYCLES - 1)) begin
                cnt_n    = '0;
                dir_n    = pend_dir;
                x_n      = step_x;
                y_n      = step_y;
                mv_req_n = 1'b1;
                state_n  = REQ;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (state == REQ && mv_ack) begin
            mv_req_n = 1'b0;
            state_n  = IDLE;
        end
    end

    // all state registers, reset overriding any pending step or handshake
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_prev <= '0;
            pend_dir <= 2'b00;
            dir      <= 2'b00;
            head_x   <= XW'(GRID_W / 2);
            head_y   <= YW'(GRID_H / 2);
            cnt      <= '0;
            mv_req   <= 1'b0;
            state    <= IDLE;
        end else begin
            key_s1   <= KEY;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            pend_dir <= pend_dir_n;
            dir      <= dir_n;
            head_x   <= x_n;
            head_y   <= y_n;
            cnt      <= cnt_n;
            mv_req   <= mv_req_n;
            state    <= state_n;
        end
    end
endmodule

// File: tb/tb_snake_head_stepper.sv
// tb_snake_head_stepper: directed checks of stepping, key filtering, wrap, handshake stall and reset
module tb_snake_head_stepper;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       enable;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [1:0] dir;
    logic       mv_req;
    logic       mv_ack;
    int         pass_cnt = 0;
    int         total = 0;

    snake_head_stepper #(.STEP_CYCLES(4)) dut (
        .CLOCK_50(clk),
        .Reset(rst),
        .KEY(key),
        .enable(enable),
        .head_x(head_x),
        .head_y(head_y),
        .dir(dir),
        .mv_req(mv_req),
        .mv_ack(mv_ack)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int d, input int r);
        chk({tag, " x"}, 32'(head_x), 32'(x));
        chk({tag, " y"}, 32'(head_y), 32'(y));
        chk({tag, " dir"}, 32'(dir), 32'(d));
        chk({tag, " req"}, 32'(mv_req), 32'(r));
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        tick(3);
        key = 4'b0000;
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        key = 4'b0000;
        enable = 1'b1;
        mv_ack = 1'b1;
        tick(2);
        chk_pos("reset", 20, 15, 0, 0);
        rst = 1'b0;
        tick(3);
        chk("pre-step req", 32'(mv_req), 0);
        tick(1);
        chk_pos("first step", 21, 15, 0, 1);
        tick(1);
        chk("ack clears req", 32'(mv_req), 0);
        tick(4);
        chk_pos("second step", 22, 15, 0, 1);
        press(4'b1000);
        chk_pos("left rejected", 23, 15, 0, 1);
        press(4'b0010);
        chk_pos("turn up", 23, 14, 1, 1);
        press(4'b0100);
        chk_pos("down rejected", 23, 13, 1, 1);
        tick(5 * 13);
        chk_pos("reach top", 23, 0, 1, 1);
        tick(5);
        chk_pos("wrap up", 23, 29, 1, 1);
        press(4'b0001);
        chk_pos("turn right", 24, 29, 0, 1);
        tick(5 * 15);
        chk_pos("reach right", 39, 29, 0, 1);
        tick(5);
        chk_pos("wrap right", 0, 29, 0, 1);
        press(4'b0100);
        chk_pos("wrap down", 0, 0, 2, 1);
        press(4'b1000);
        chk_pos("wrap left", 39, 0, 3, 1);
        tick(4);
        mv_ack = 1'b0;
        tick(1);
        chk_pos("stall start", 38, 0, 3, 1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_pos("stall hold", 38, 0, 3, 1);
        end
        mv_ack = 1'b1;
        tick(1);
        chk("stall ack", 32'(mv_req), 0);
        tick(3);
        chk("post-stall idle", 32'(mv_req), 0);
        tick(1);
        chk_pos("post-stall step", 37, 0, 3, 1);
        press(4'b0010);
        chk_pos("left to up", 37, 29, 1, 1);
        press(4'b0001);
        chk_pos("up to right", 38, 29, 0, 1);
        press(4'b0110);
        chk_pos("dual press", 38, 28, 1, 1);
        tick(3);
        enable = 1'b0;
        tick(10);
        chk_pos("frozen", 38, 28, 1, 0);
        enable = 1'b1;
        tick(1);
        chk("resume count", 32'(mv_req), 0);
        tick(1);
        chk_pos("resume step", 38, 27, 1, 1);
        mv_ack = 1'b0;
        rst = 1'b1;
        tick(1);
        chk_pos("reset in req", 20, 15, 0, 0);
        rst = 1'b0;
        mv_ack = 1'b1;
        tick(3);
        chk("post-reset idle", 32'(mv_req), 0);
        tick(1);
        chk_pos("post-reset step", 21, 15, 0, 1);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
